// File: rtl/aes_job_dispatch_if.sv
// ---------------------------------------------------------------------------
// aes_job_dispatch_if
// Requester/response bundle for aes_job_dispatch.
//   req_valid/req_ready/req_mode  per-channel job handshake and mode
//                                 (0 = encrypt, 1 = decrypt)
//   req_key/req_text              per-channel 128-bit key and block,
//                                 channel i at [128*i +: 128]
//   rsp_valid/rsp_ready           result handshake
//   rsp_ch/rsp_mode/rsp_text      originating channel, mode and result block
// Modports: master = requester side, slave = dispatcher side.
// ---------------------------------------------------------------------------
interface aes_job_dispatch_if #(
    parameter int unsigned NUM_CH = 2
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]     req_valid;
    logic [NUM_CH-1:0]     req_ready;
    logic [NUM_CH-1:0]     req_mode;
    logic [NUM_CH*128-1:0] req_key;
    logic [NUM_CH*128-1:0] req_text;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [CH_W-1:0]       rsp_ch;
    logic                  rsp_mode;
    logic [127:0]          rsp_text;

    modport master (
        output req_valid, req_mode, req_key, req_text, rsp_ready,
        input  req_ready, rsp_valid, rsp_ch, rsp_mode, rsp_text
    );

    modport slave (
        input  req_valid, req_mode, req_key, req_text, rsp_ready,
        output req_ready, rsp_valid, rsp_ch, rsp_mode, rsp_text
    );
endinterface

// File: rtl/aes_job_dispatch.sv
// ---------------------------------------------------------------------------
// aes_job_dispatch
// Job front end for an AES cipher core and an AES inverse-cipher core.
// Round-robin arbitrates NUM_CH requesters, sequences enc_ld or dec_kld/dec_ld
// for one job at a time and returns the result with its channel tag.
//
// Parameters: NUM_CH (requester channels), KEY_WAIT (cycles after dec_kld
//             before dec_ld is legal).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   bus (slave)         requester and response handshakes (aes_job_dispatch_if)
//   err                 sticky: unexpected done pulse seen
//   core_key/core_text  latched job key/block, shared by both cores
//   enc_ld/enc_done/enc_text            cipher core control and result
//   dec_kld/dec_ld/dec_done/dec_text    inverse-cipher control and result
//
// Optional feature, macro AES_KEY_CACHE_EN: remember the last key expanded in
// the inverse cipher so a decrypt with the same key skips key expansion.
// ---------------------------------------------------------------------------
module aes_job_dispatch #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned KEY_WAIT = 10
) (
    input  logic                clk,
    input  logic                rst,
    aes_job_dispatch_if.slave   bus,
    output logic                err,
    output logic [127:0]        core_key,
    output logic [127:0]        core_text,
    output logic                enc_ld,
    input  logic                enc_done,
    input  logic [127:0]        enc_text,
    output logic                dec_kld,
    output logic                dec_ld,
    input  logic                dec_done,
    input  logic [127:0]        dec_text
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;

    typedef enum logic [2:0] {IDLE, KEYEXP, LOAD, BUSY, RESP} state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] last_q, last_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            mode_q, mode_d;
    logic [127:0]    key_q, key_d;
    logic [127:0]    text_q, text_d;
    logic [CH_W-1:0] rsp_ch_q, rsp_ch_d;
    logic            rsp_mode_q, rsp_mode_d;
    logic [127:0]    rsp_text_q, rsp_text_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [NUM_CH-1:0] gnt;
    logic [127:0]      gnt_key;
    logic              cache_hit;

    // Round-robin: first requesting channel strictly above last_q, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((32'(last_q) + i) % NUM_CH);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Grant is also gated by rst so every output reads 0 while reset is held.
    always_comb begin
        gnt          = '0;
        gnt[gnt_idx] = gnt_any && (state_q == IDLE) && rst;
    end

    assign gnt_key = bus.req_key[128*gnt_idx +: 128];

`ifdef AES_KEY_CACHE_EN
    logic [127:0] cache_key_q, cache_key_d;
    logic         cache_vld_q, cache_vld_d;

    always_comb begin
        cache_key_d = cache_key_q;
        cache_vld_d = cache_vld_q;
        if (dec_kld) begin
            cache_key_d = key_q;
            cache_vld_d = 1'b1;
        end
    end

    assign cache_hit = cache_vld_q && (cache_key_q == gnt_key);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_key_q <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_key_q <= cache_key_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        ch_d       = ch_q;
        mode_d     = mode_q;
        key_d      = key_q;
        text_d     = text_q;
        rsp_ch_d   = rsp_ch_q;
        rsp_mode_d = rsp_mode_q;
        rsp_text_d = rsp_text_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        enc_ld     = 1'b0;
        dec_ld     = 1'b0;
        dec_kld    = 1'b0;
        bus.rsp_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    last_d  = gnt_idx;
                    ch_d    = gnt_idx;
                    mode_d  = bus.req_mode[gnt_idx];
                    key_d   = gnt_key;
                    text_d  = bus.req_text[128*gnt_idx +: 128];
                    cnt_d   = '0;
                    state_d = (bus.req_mode[gnt_idx] && !cache_hit) ? KEYEXP : LOAD;
                end
            end
            KEYEXP: begin
                dec_kld = (cnt_q == '0);
                if (cnt_q == CNT_W'(KEY_WAIT - 1)) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                enc_ld  = !mode_q;
                dec_ld  = mode_q;
                state_d = BUSY;
            end
            BUSY: begin
                if (mode_q ? dec_done : enc_done) begin
                    rsp_text_d = mode_q ? dec_text : enc_text;
                    rsp_ch_d   = ch_q;
                    rsp_mode_d = mode_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Done from the wrong engine in BUSY, or any done elsewhere, is flagged.
        if (state_q == BUSY) begin
            if (mode_q ? enc_done : dec_done) begin
                err_d = 1'b1;
            end
        end else if (enc_done || dec_done) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= CH_W'(NUM_CH - 1);
            ch_q       <= '0;
            mode_q     <= 1'b0;
            key_q      <= '0;
            text_q     <= '0;
            rsp_ch_q   <= '0;
            rsp_mode_q <= 1'b0;
            rsp_text_q <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            ch_q       <= ch_d;
            mode_q     <= mode_d;
            key_q      <= key_d;
            text_q     <= text_d;
            rsp_ch_q   <= rsp_ch_d;
            rsp_mode_q <= rsp_mode_d;
            rsp_text_q <= rsp_text_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_ch    = rsp_ch_q;
    assign bus.rsp_mode  = rsp_mode_q;
    assign bus.rsp_text  = rsp_text_q;
    assign err           = err_q;
    assign core_key      = key_q;
    assign core_text     = text_q;
endmodule
